mux_3: RTL and testbench
========================

// Module: mux_3
// PURPOSE
//  - Write-back source select for the MIPS datapath: picks the register-file write data
//    from the return PC (call), memory load data (load) or the ALU result (default).
//  - Sits between the MEM stage outputs and the register-file write port.
//  - Data path is combinational by default.
//  - A registered output stage can be compiled in.
// PARAMETERS
//  - WIDTH  32  data width of in_pc, in_mem, in_alu and data
// PORTS
//  - clk           in   1      system clock; used only by the registered stage and the sticky flag
//  - rst_n         in   1      asynchronous, active-low reset
//  - in_pc         in   WIDTH  return/link PC value, selected on call
//  - in_mem        in   WIDTH  load data from data memory
//  - in_alu        in   WIDTH  ALU result
//  - isLd          in   1      current instruction is a load
//  - isCall        in   1      current instruction is a call
//  - data          out  WIDTH  selected write-back data
//  - sel_conflict  out  1      sticky flag: isLd and isCall were both seen high on a clk edge
// BEHAVIOUR
//  - Clocking and reset: one clock (clk); rst_n is asynchronous and active-low.
//  - Selection, with fixed priority:
//    - isCall=1 -> data = in_pc
//    - else isLd=1 -> data = in_mem
//    - else -> data = in_alu
//  - Simultaneous isCall=1 and isLd=1 -> in_pc wins (call has priority).
//  - X/Z on a select line: must not propagate as a latch; use a full case with in_alu as default.
//  - Default build:
//    - data is purely combinational; zero latency.
//    - data follows input changes within the same delta cycle, with no clock required.
//    - rst_n has no effect on data.
//  - sel_conflict:
//    - Register, cleared to 0 asynchronously while rst_n=0.
//    - Set to 1 on a rising clk edge when isLd & isCall; then holds 1 until reset.
//  - Reset asserted mid-operation:
//    - sel_conflict clears immediately.
//    - The combinational data path is unaffected.
//  - No arithmetic is performed; all paths are WIDTH bits, with no extension or truncation.
// CONFIGURATION
//  - Macro MUX3_OUT_REG_EN.
//  - Undefined (default): data is combinational, as above.
//  - Defined:
//    - data is registered: data <= selected value on each rising clk edge (1-cycle latency).
//    - data resets asynchronously to 0 while rst_n=0.
//    - Selection and priority rules are unchanged.
//    - sel_conflict behaviour is unchanged.
// TESTING
//  - All inputs 0, rst_n pulsed low then high -> data=0, sel_conflict=0.
//  - Set in_pc=32'hFF000000, in_mem=32'h00FF0000, in_alu=32'h0000FF00:
//    - isLd=0, isCall=0 -> data=32'h0000FF00
//    - isLd=1, isCall=0 -> data=32'h00FF0000
//    - isLd=0, isCall=1 -> data=32'hFF000000
//  - Conflict: isLd=1, isCall=1 -> data=32'hFF000000.
//    - After the next clk edge, sel_conflict=1; it stays 1 after both selects drop.
//    - Assert rst_n=0 -> sel_conflict=0 at once, without waiting for a clock.
//  - With MUX3_OUT_REG_EN defined, repeat the select sequence:
//    - data updates one clk edge after each select change.
//    - data is 0 during reset.

Source files
------------

// File: rtl/mux_3.sv
// rtl/mux_3.sv - write-back source select (call PC / load data / ALU) with sticky select-conflict flag; optional output register under MUX3_OUT_REG_EN
module mux_3 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_mem,
  input  logic [WIDTH-1:0] in_alu,
  input  logic             isLd,
  input  logic             isCall,
  output logic [WIDTH-1:0] data,
  output logic             sel_conflict
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_conflict_d;
  logic             sel_conflict_q;

  // Priority select: call beats load, anything else (including X/Z selects) takes the ALU result.
  always_comb begin
    sel_data = in_alu;
    case ({isCall, isLd})
      2'b10, 2'b11: sel_data = in_pc;
      2'b01:        sel_data = in_mem;
      default:      sel_data = in_alu;
    endcase
  end

  // Conflict flag sets when both selects are high and stays set until reset.
  always_comb begin
    sel_conflict_d = sel_conflict_q | (isLd & isCall);
  end

  // Sticky conflict register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_conflict_q <= 1'b0;
    end else begin
      sel_conflict_q <= sel_conflict_d;
    end
  end

  assign sel_conflict = sel_conflict_q;

`ifdef MUX3_OUT_REG_EN
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next output value is simply the current selection.
  always_comb begin
    data_d = sel_data;
  end

  // Registered output stage: one cycle of latency, zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;
`else
  assign data = sel_data;
`endif

endmodule

// File: tb/tb_mux_3.sv
// tb/tb_mux_3.sv - self-checking bench for mux_3 (model-based per-cycle compare plus directed literals)
module tb_mux_3;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_pc, in_mem, in_alu;
  logic         isLd, isCall;
  logic [W-1:0] data;
  logic         sel_conflict;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  mux_3 #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_pc        (in_pc),
    .in_mem       (in_mem),
    .in_alu       (in_alu),
    .isLd         (isLd),
    .isCall       (isCall),
    .data         (data),
    .sel_conflict (sel_conflict)
  );

  always #5 clk = ~clk;

  // Reference selection from the rules: call first, then load, else ALU.
  function automatic logic [W-1:0] ref_sel(input logic [W-1:0] pc, mem, alu,
                                           input logic ld, call);
    if (call === 1'b1) return pc;
    if (ld === 1'b1)   return mem;
    return alu;
  endfunction

  // Model state: sticky flag seen at clock edges, and the registered output when built in.
  logic         m_flag;
  logic [W-1:0] m_reg;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flag <= 1'b0;
      m_reg  <= '0;
    end else begin
      if (isLd && isCall) m_flag <= 1'b1;
      m_reg <= ref_sel(in_pc, in_mem, in_alu, isLd, isCall);
    end
  end

  function automatic logic [W-1:0] m_data();
`ifdef MUX3_OUT_REG_EN
    return m_reg;
`else
    return ref_sel(in_pc, in_mem, in_alu, isLd, isCall);
`endif
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_data", data, m_data());
      check("cyc_conflict", {31'b0, sel_conflict}, {31'b0, m_flag});
    end
  end

  // Change selects just after an edge and check the directed expectation.
  task automatic apply(input logic ld, input logic call, input logic [W-1:0] exp,
                       input logic [W-1:0] prev, input string name);
    @(posedge clk); #1;
    isLd = ld; isCall = call;
    #1;
`ifdef MUX3_OUT_REG_EN
    check({name, "_hold"}, data, prev);
    @(posedge clk); #1;
`else
    if (prev !== 'x) begin end
`endif
    check(name, data, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    in_pc = '0; in_mem = '0; in_alu = '0;
    isLd = 1'b0; isCall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data, 32'h0);
    check("reset_conflict", {31'b0, sel_conflict}, 32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    @(posedge clk); #1;
    in_pc = 32'hFF000000; in_mem = 32'h00FF0000; in_alu = 32'h0000FF00;
`ifdef MUX3_OUT_REG_EN
    @(posedge clk); #1;
`else
    #1;
`endif
    check("sel_alu", data, 32'h0000FF00);
    apply(1'b1, 1'b0, 32'h00FF0000, 32'h0000FF00, "sel_mem");
    apply(1'b0, 1'b1, 32'hFF000000, 32'h00FF0000, "sel_pc");
    check("no_conflict_yet", {31'b0, sel_conflict}, 32'h0);
    apply(1'b0, 1'b0, 32'h0000FF00, 32'hFF000000, "sel_alu2");

    // Conflict: call wins, flag sets on the following edge and sticks.
    @(posedge clk); #1;
    isLd = 1'b1; isCall = 1'b1;
    #1;
`ifndef MUX3_OUT_REG_EN
    check("conflict_data", data, 32'hFF000000);
`endif
    check("conflict_before_edge", {31'b0, sel_conflict}, 32'h0);
    @(posedge clk); #1;
`ifdef MUX3_OUT_REG_EN
    check("conflict_data", data, 32'hFF000000);
`endif
    check("conflict_set", {31'b0, sel_conflict}, 32'h1);
    isLd = 1'b0; isCall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("conflict_sticky", {31'b0, sel_conflict}, 32'h1);
    check("after_conflict_data", data, 32'h0000FF00);

    // Asynchronous reset mid-operation, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", {31'b0, sel_conflict}, 32'h0);
`ifdef MUX3_OUT_REG_EN
    check("reset_data_reg", data, 32'h0);
`else
    check("reset_data_comb", data, 32'h0000FF00);
    in_alu = 32'h12345678;
    #1;
    check("comb_in_reset", data, 32'h12345678);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Boundary patterns: all ones on one input, zero on the others.
    in_pc = 32'hFFFFFFFF; in_mem = 32'h0; in_alu = 32'h0;
    apply(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, "pc_ones");
    in_pc = 32'h0; in_mem = 32'hFFFFFFFF;
    apply(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, "mem_ones");

    // Random vectors, checked by the per-cycle compare.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      in_pc  = $urandom; in_mem = $urandom; in_alu = $urandom;
      isLd   = 1'($urandom_range(0, 1));
      isCall = (i > 30) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(posedge clk); #1;
    isLd = 1'b0; isCall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
